// File: rtl/rv32_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_div_unit
//  Description : Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient
//                bit per cycle via restoring subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] input_a,
    input  logic [XLEN-1:0] input_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0]      c_OP_DIV  = 2'b00;
    localparam logic [1:0]      c_OP_DIVU = 2'b01;
    localparam logic [1:0]      c_OP_REM  = 2'b10;
    localparam logic [5:0]      c_LAST    = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_special;
    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;

    logic            w_signed;
    logic [XLEN-1:0] w_opnd_a;
    logic [XLEN-1:0] w_opnd_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_fix_result;

    assign w_signed  = ~op[0];
    assign w_opnd_a  = (w_signed && input_a[XLEN-1]) ? -input_a : input_a;
    assign w_opnd_b  = (w_signed && input_b[XLEN-1]) ? -input_b : input_b;
    assign w_b_zero  = (input_b == '0);
    assign w_ovf     = w_signed && (input_a == c_MIN) && (input_b == '1);

    assign w_shifted = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_diff    = {1'b0, w_shifted} - {1'b0, r_div};

    always_comb begin
        w_fix_result = r_rem;
        case (r_op)
            c_OP_DIV:  w_fix_result = r_neg_q ? -r_quo : r_quo;
            c_OP_DIVU: w_fix_result = r_quo;
            c_OP_REM:  w_fix_result = r_neg_r ? -r_rem : r_rem;
            default:   w_fix_result = r_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= 2'b00;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_cnt     <= 6'd0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_neg_q <= w_signed & (input_a[XLEN-1] ^ input_b[XLEN-1]);
                        r_neg_r <= w_signed & input_a[XLEN-1];
                        r_cnt   <= 6'd0;
                        r_rem   <= '0;
                        r_quo   <= w_opnd_a;
                        r_div   <= w_opnd_b;
                        busy    <= 1'b1;
                        // Special cases settle result now and ride through FIX
                        // untouched, so done lands two cycles after accept.
                        if (w_b_zero) begin
                            result    <= op[1] ? input_a : '1;
                            r_special <= 1'b1;
                            r_state   <= FIX;
                        end else if (w_ovf) begin
                            result    <= op[1] ? '0 : c_MIN;
                            r_special <= 1'b1;
                            r_state   <= FIX;
                        end else begin
                            r_special <= 1'b0;
                            r_state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!w_diff[XLEN]) begin
                        r_rem <= w_diff[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shifted;
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!r_special) begin
                        result <= w_fix_result;
                    end
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_div_unit
//  Description : Scoreboard bench for the iterative RV32M divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_div_unit;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;
    localparam int         c_LIMIT = 60;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    rv32_div_unit #(.XLEN(32)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .input_a (input_a),
        .input_b (input_b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            c_DIV:   return 32'(sa / sb);
            c_DIVU:  return a / b;
            c_REM:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 2;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding issue.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
            else                   check("result", result, exp_q.pop_front());
        end
    end

    task automatic wait_done(input string tag, input int lat, inout int n);
        while (done !== 1'b1 && n < c_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; input_a = a; input_b = b;
        exp_q.push_back(ref_div(o, a, b));
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); input_a = $urandom; input_b = $urandom;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        wait_done(tag, ref_lat(o, a, b), n);
        @(negedge clk);
        check({tag, "_idle"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        int n;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;

        run_op("divu_100_7", c_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", c_REMU, 32'd100, 32'd7);
        run_op("div_m7_2", c_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", c_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_by0", c_DIVU, 32'd5, 32'd0);
        run_op("remu_by0", c_REMU, 32'd5, 32'd0);
        run_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", c_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_by0", c_DIV, 32'hFFFF_FFF0, 32'd0);
        run_op("rem_by0", c_REM, 32'hFFFF_FFF0, 32'd0);
        run_op("div_neg_neg", c_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_op("rem_pos_neg", c_REM, 32'd100, 32'hFFFF_FFF9);
        run_op("divu_big", c_DIVU, 32'hFFFF_FFFF, 32'd1);
        run_op("remu_small_big", c_REMU, 32'd3, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            ro = 2'(i);
            ra = $urandom;
            rb = (i > 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op("random", ro, ra, rb);
        end

        // Start pulsed mid-operation must be dropped, not queued.
        @(negedge clk);
        start = 1'b1; op = c_DIVU; input_a = 32'hFFFF_FFFF; input_b = 32'd1;
        exp_q.push_back(32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1; op = c_REMU; input_a = 32'd3; input_b = 32'd2;
        @(negedge clk);
        n++;
        start = 1'b0;
        wait_done("ignored_start", 34, n);
        repeat (3) @(negedge clk);
        check("no_queue_busy", 32'(busy), 32'd0);

        // Held start: ignored during the done cycle, accepted on return to IDLE.
        @(negedge clk);
        start = 1'b1; op = c_DIVU; input_a = 32'd100; input_b = 32'd7;
        exp_q.push_back(32'd14);
        @(negedge clk);
        op = c_REMU;
        exp_q.push_back(32'd2);
        n = 1;
        wait_done("held_first", 34, n);
        @(negedge clk);
        check("held_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("held_second_busy", 32'(busy), 32'd1);
        n = 1;
        wait_done("held_second", 34, n);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; op = c_DIV; input_a = 32'd100; input_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_still_idle", 32'({done, busy}), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
